// File: rtl/maxpool2x2.sv
// 2x2 stride-2 max-pooling stage with optional fused ReLU on a raster-order pixel stream.
// Even rows leave per-pair partial maxima in a half-width line buffer; odd rows complete the window.
module maxpool2x2 #(
  parameter int DATA_W  = 8,
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int RELU_EN = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     valid_out,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     last_out
);

  localparam int HALF_W = IMG_W / 2;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic signed [DATA_W-1:0] h_reg;
  logic signed [DATA_W-1:0] lbuf [HALF_W];
  logic [LB_AW-1:0]         lb_idx;
  logic                     col_last;
  logic                     frame_last;
  logic signed [DATA_W-1:0] hmax_p0;
  logic signed [DATA_W-1:0] pooled_p0;

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [DATA_W-1:0] relu_clamp(input logic signed [DATA_W-1:0] v);
    if ((RELU_EN != 0) && (v < 0)) return '0;
    return v;
  endfunction

  assign lb_idx     = LB_AW'(col >> 1);
  assign col_last   = (col == COL_MAX);
  assign frame_last = col_last && (row == ROW_MAX);
  assign hmax_p0    = smax(h_reg, data_in);
  assign pooled_p0  = relu_clamp(smax(lbuf[lb_idx], hmax_p0));

  // Line buffer is written before it is ever read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (valid_in && !clear && col[0] && !row[0]) lbuf[lb_idx] <= hmax_p0;
  end

  // Stage boundary: window result registered onto the outputs one clock after its last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      h_reg     <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      last_out  <= 1'b0;
    end else if (clear) begin
      col       <= '0;
      row       <= '0;
      h_reg     <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      if (valid_in) begin
        if (col_last) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          h_reg <= data_in;
        end else if (row[0]) begin
          valid_out <= 1'b1;
          data_out  <= pooled_p0;
          last_out  <= frame_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2.sv
// Randomized bench for maxpool2x2 on 4x4 frames, with and without ReLU, against a frame-array model.
module tb_maxpool2x2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic valid_in = 1'b0;
  logic signed [7:0] data_in = '0;
  logic v0, v1, l0, l1;
  logic signed [7:0] d0, d1;

  always #5 clk = ~clk;

  maxpool2x2 #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .RELU_EN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .data_in(data_in),
    .valid_out(v0), .data_out(d0), .last_out(l0));

  maxpool2x2 #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .RELU_EN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .data_in(data_in),
    .valid_out(v1), .data_out(d1), .last_out(l1));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: whole frame kept as an array; a window's max is taken when its bottom-right pixel lands.
  int pix [16];
  int cnt;
  bit ev, el;
  int ed0, ed1;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int wmax(input int idx, input int din);
    int r = idx / 4;
    int c = idx % 4;
    return imax(imax(pix[(r-1)*4 + c-1], pix[(r-1)*4 + c]), imax(pix[r*4 + c-1], din));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      cnt <= 0; ev <= 1'b0; el <= 1'b0; ed0 <= 0; ed1 <= 0;
    end else begin
      ev <= 1'b0;
      el <= 1'b0;
      if (valid_in) begin
        pix[cnt] <= int'(data_in);
        cnt <= (cnt + 1) % 16;
        if (((cnt / 4) % 2 == 1) && (cnt % 2 == 1)) begin
          ev  <= 1'b1;
          ed0 <= wmax(cnt, int'(data_in));
          ed1 <= imax(wmax(cnt, int'(data_in)), 0);
          el  <= (cnt == 15);
        end
      end
    end
  end

  int q0[$], q1[$], ql[$];

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("valid_out0", int'(v0), int'(ev));
      chk("valid_out1", int'(v1), int'(ev));
      chk("last_out0", int'(l0), int'(el));
      chk("last_out1", int'(l1), int'(el));
      chk("data_out0", int'(d0), ed0);
      chk("data_out1", int'(d1), ed1);
    end
    if (v0) begin q0.push_back(int'(d0)); ql.push_back(int'(l0)); end
    if (v1) q1.push_back(int'(d1));
  end

  task automatic chk_q(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk(nm, got[i], exp[i]);
  endtask

  task automatic drive(input bit v, input int d);
    @(negedge clk);
    valid_in = v;
    data_in  = d[7:0];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0);
  endtask

  logic signed [7:0] fr [16];

  task automatic send_fr(input int gaps);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, int'(fr[i]));
      if (gaps > 0) idle($urandom_range(1, gaps));
    end
  endtask

  task automatic ramp(input int base);
    for (int i = 0; i < 16; i++) fr[i] = 8'(base + i);
  endtask

  task automatic flush_clear();
    idle(3);
    q0.delete(); q1.delete(); ql.delete();
  endtask

  initial begin
    int e[$], el_q[$], er[$];
    logic signed [7:0] vals [4];
    int k;
    logic signed [7:0] t;

    repeat (3) @(negedge clk);
    chk("reset_valid", int'(v0), 0);
    chk("reset_data", int'(d0), 0);
    chk("reset_last", int'(l1), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // T1 contiguous ramp
    ramp(0); send_fr(0); idle(3);
    e = '{5, 7, 13, 15}; el_q = '{0, 0, 0, 1};
    chk_q("t1_data0", q0, e); chk_q("t1_data1", q1, e); chk_q("t1_last", ql, el_q);
    flush_clear();

    // T2 ramp with idle gaps
    ramp(0); send_fr(3); idle(3);
    chk_q("t2_data0", q0, e); chk_q("t2_last", ql, el_q);
    flush_clear();

    // T3 windows of three -128 and one -1
    for (int i = 0; i < 16; i++) fr[i] = -8'sd128;
    for (int wr = 0; wr < 4; wr += 2)
      for (int wc = 0; wc < 4; wc += 2) begin
        k = $urandom_range(0, 3);
        fr[(wr + k/2)*4 + wc + k%2] = -8'sd1;
      end
    send_fr(2); idle(3);
    e = '{-1, -1, -1, -1}; er = '{0, 0, 0, 0};
    chk_q("t3_data0", q0, e); chk_q("t3_relu", q1, er);
    flush_clear();

    // T4 shuffled {127,-128,0,-1} windows, then all -128
    for (int wr = 0; wr < 4; wr += 2)
      for (int wc = 0; wc < 4; wc += 2) begin
        vals[0] = 8'sd127; vals[1] = -8'sd128; vals[2] = 8'sd0; vals[3] = -8'sd1;
        for (int j = 3; j > 0; j--) begin
          k = $urandom_range(0, j);
          t = vals[j]; vals[j] = vals[k]; vals[k] = t;
        end
        for (int j = 0; j < 4; j++) fr[(wr + j/2)*4 + wc + j%2] = vals[j];
      end
    send_fr(0); idle(3);
    e = '{127, 127, 127, 127};
    chk_q("t4_max", q0, e);
    flush_clear();
    for (int i = 0; i < 16; i++) fr[i] = -8'sd128;
    send_fr(0); idle(3);
    e = '{-128, -128, -128, -128};
    chk_q("t4_min", q0, e); chk_q("t4_min_relu", q1, er);
    flush_clear();

    // T5 back-to-back frames
    ramp(0); send_fr(0); ramp(100); send_fr(0); idle(3);
    e = '{5, 7, 13, 15, 105, 107, 113, 115}; el_q = '{0, 0, 0, 1, 0, 0, 0, 1};
    chk_q("t5_data", q0, e); chk_q("t5_last", ql, el_q);
    flush_clear();

    // T6a clear mid-frame, with a pixel offered on the clear cycle
    for (int i = 0; i < 6; i++) drive(1'b1, i);
    @(negedge clk); clear = 1'b1; valid_in = 1'b1; data_in = 8'sd99;
    @(negedge clk); clear = 1'b0; valid_in = 1'b0;
    q0.delete(); q1.delete(); ql.delete();
    ramp(0); send_fr(0); idle(3);
    e = '{5, 7, 13, 15}; el_q = '{0, 0, 0, 1};
    chk_q("t6_clear", q0, e); chk_q("t6_clear_last", ql, el_q);
    flush_clear();

    // T6b async reset mid-frame
    for (int i = 0; i < 6; i++) drive(1'b1, i);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(v0), 0);
    chk("t6_rst_data0", int'(d0), 0);
    chk("t6_rst_data1", int'(d1), 0);
    idle(2);
    rst_n = 1'b1;
    q0.delete(); q1.delete(); ql.delete();
    ramp(0); send_fr(0); idle(3);
    chk_q("t6_rst", q0, e); chk_q("t6_rst_last", ql, el_q);
    flush_clear();

    // Random frames, random gaps, model-checked every cycle
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 16; i++) fr[i] = 8'($urandom_range(0, 255));
      send_fr($urandom_range(0, 2));
    end
    idle(3);
    chk("rand_count", q0.size(), 24);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
